// File: rtl/axi_wr_sched.sv
// axi_wr_sched: round-robin scheduler sharing one single-beat AXI3 write port, with in-order B routing
module axi_wr_sched #(
   parameter int NREQ = 2,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MAX_OUTST = 4,
   localparam int OW = $clog2(MAX_OUTST + 1),
   localparam int TW = $clog2(NREQ),
   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [1:0]         rsp_code,
   output logic               awvalid,
   input  logic               awready,
   output logic [AW-1:0]      awaddr,
   output logic [3:0]         awlen,
   output logic [2:0]         awsize,
   output logic               wvalid,
   input  logic               wready,
   output logic [DW-1:0]      wdata,
   output logic [DW/8-1:0]    wstrb,
   output logic               wlast,
   input  logic               bvalid,
   output logic               bready,
   input  logic [1:0]         bresp,
   output logic [OW-1:0]      outst,
   output logic [7:0]         err_cnt
);
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state_q, state_d;
   logic [TW-1:0] ptr_q, ptr_d, win_q, win_d, sel;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [1:0] rsp_code_q, rsp_code_d;
   logic [OW-1:0] outst_q, outst_d;
   logic [7:0] err_q, err_d;
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [TW-1:0] tag_q [MAX_OUTST];
   logic found, grant, push, pop;

   // round-robin search starting just after the last winner
   always_comb begin
      found = 1'b0;
      sel = ptr_q;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
            found = 1'b1;
            sel = TW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   // grant uses the registered outstanding count, so a pop cycle cannot also grant at the limit
   assign grant = state_q == IDLE && found && outst_q < OW'(MAX_OUTST);
   assign push = state_q == ISSUE && (!awvalid_q || awready) && (!wvalid_q || wready);
   assign pop = bvalid && outst_q != '0;

   // next-state for the issue FSM, tag FIFO pointers and response bookkeeping
   always_comb begin
      state_d = grant ? ISSUE : push ? IDLE : state_q;
      ptr_d = grant ? sel : ptr_q;
      win_d = grant ? sel : win_q;
      addr_d = grant ? req_addr[sel*AW +: AW] : addr_q;
      data_d = grant ? req_data[sel*DW +: DW] : data_q;
      awvalid_d = grant | (awvalid_q & ~awready);
      wvalid_d = grant | (wvalid_q & ~wready);
      wr_d = push ? (wr_q == PW'(MAX_OUTST - 1) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d = pop ? (rd_q == PW'(MAX_OUTST - 1) ? '0 : rd_q + 1'b1) : rd_q;
      outst_d = outst_q + OW'(push) - OW'(pop);
      rsp_valid_d = pop ? NREQ'(1) << tag_q[rd_q] : '0;
      rsp_code_d = pop ? bresp : rsp_code_q;
      err_d = pop && bresp[1] && err_q != 8'hFF ? err_q + 8'd1 : err_q;
   end

   // state registers; reset abandons any in-flight AW/W and outstanding tags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= TW'(NREQ - 1);
         win_q <= '0;
         addr_q <= '0;
         data_q <= '0;
         awvalid_q <= 1'b0;
         wvalid_q <= 1'b0;
         wr_q <= '0;
         rd_q <= '0;
         outst_q <= '0;
         rsp_valid_q <= '0;
         rsp_code_q <= '0;
         err_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         win_q <= win_d;
         addr_q <= addr_d;
         data_q <= data_d;
         awvalid_q <= awvalid_d;
         wvalid_q <= wvalid_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         outst_q <= outst_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_code_q <= rsp_code_d;
         err_q <= err_d;
      end
   end

   // tag FIFO storage; contents are meaningless once the pointers are reset
   always_ff @(posedge clk) begin
      if (push) tag_q[wr_q] <= win_q;
   end

   assign req_ready = grant ? NREQ'(1) << sel : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_code = rsp_code_q;
   assign awvalid = awvalid_q;
   assign awaddr = addr_q;
   assign awlen = 4'd0;
   assign awsize = 3'($clog2(DW / 8));
   assign wvalid = wvalid_q;
   assign wdata = data_q;
   assign wstrb = '1;
   assign wlast = wvalid_q;
   assign bready = outst_q != '0;
   assign outst = outst_q;
   assign err_cnt = err_q;
endmodule
